// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file behind a two-state IDLE/ACCESS handshake, with trap/mret hooks.
// Define CSR_COUNTERS_EN to add the 64-bit mcycle counter (0xB00, plus mcycleh at 0xB80 for 32-bit).
module csr_unit #(
  parameter int CSR_DATA_WIDTH = 32,
  parameter int CSR_ADDR_WIDTH = 12,
  parameter logic [CSR_DATA_WIDTH-1:0] HART_ID = '0,
  parameter logic [CSR_DATA_WIDTH-1:0] MTVEC_RESET = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      csr_en_i,
  input  logic [1:0]                csr_op_i,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_addr_i,
  input  logic [CSR_DATA_WIDTH-1:0] csr_data_i,
  output logic [CSR_DATA_WIDTH-1:0] csr_data_o,
  output logic                      csr_busy_o,
  output logic                      csr_done_o,
  output logic                      csr_exists_o,
  output logic                      csr_ro_o,
  input  logic                      trap_i,
  input  logic [CSR_DATA_WIDTH-1:0] trap_cause_i,
  input  logic [CSR_DATA_WIDTH-1:0] trap_pc_i,
  input  logic [CSR_DATA_WIDTH-1:0] trap_val_i,
  input  logic                      mret_i,
  input  logic [1:0]                irq_i,
  output logic [CSR_DATA_WIDTH-1:0] mtvec_o,
  output logic [CSR_DATA_WIDTH-1:0] mepc_o,
  output logic                      irq_pending_o
);

  localparam int W  = CSR_DATA_WIDTH;
  localparam int AW = CSR_ADDR_WIDTH;

  localparam logic [AW-1:0] ADDR_MSTATUS   = AW'(12'h300);
  localparam logic [AW-1:0] ADDR_MISA      = AW'(12'h301);
  localparam logic [AW-1:0] ADDR_MIE       = AW'(12'h304);
  localparam logic [AW-1:0] ADDR_MTVEC     = AW'(12'h305);
  localparam logic [AW-1:0] ADDR_MSCRATCH  = AW'(12'h340);
  localparam logic [AW-1:0] ADDR_MEPC      = AW'(12'h341);
  localparam logic [AW-1:0] ADDR_MCAUSE    = AW'(12'h342);
  localparam logic [AW-1:0] ADDR_MTVAL     = AW'(12'h343);
  localparam logic [AW-1:0] ADDR_MIP       = AW'(12'h344);
  localparam logic [AW-1:0] ADDR_MTAGS     = AW'(12'h7C0);
  localparam logic [AW-1:0] ADDR_MVENDORID = AW'(12'hF11);
  localparam logic [AW-1:0] ADDR_MARCHID   = AW'(12'hF12);
  localparam logic [AW-1:0] ADDR_MHARTID   = AW'(12'hF14);
`ifdef CSR_COUNTERS_EN
  localparam logic [AW-1:0] ADDR_MCYCLE    = AW'(12'hB00);
  localparam logic [AW-1:0] ADDR_MCYCLEH   = AW'(12'hB80);
`endif

  localparam logic [1:0] MXL = (W == 64) ? 2'd2 : 2'd1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t         state;
  logic [1:0]     op_q;
  logic [AW-1:0]  addr_q;
  logic [W-1:0]   wdata_q;

  logic           st_mie;
  logic           st_mpie;
  logic [1:0]     mie_q;
  logic [1:0]     mip_q;
  logic [W-1:0]   mtvec_q;
  logic [W-1:0]   mscratch_q;
  logic [W-1:0]   mepc_q;
  logic [W-1:0]   mcause_q;
  logic [W-1:0]   mtval_q;
  logic [W-1:0]   mtags_q;
`ifdef CSR_COUNTERS_EN
  logic [63:0]    mcycle_q;
`endif

  logic [W-1:0]   rdata;
  logic           hit;
  logic           ro_addr;
  logic [W-1:0]   wval;
  logic           do_write;

  // mie/mip keep only bit 7 (timer, index 0) and bit 11 (external, index 1).
  always_comb begin
    rdata = '0;
    hit   = 1'b1;
    case (addr_q)
      ADDR_MSTATUS: begin
        rdata[12:11] = 2'b11;
        rdata[7]     = st_mpie;
        rdata[3]     = st_mie;
      end
      ADDR_MISA: begin
        rdata[W-1:W-2] = MXL;
        rdata[8]       = 1'b1;
      end
      ADDR_MIE: begin
        rdata[7]  = mie_q[0];
        rdata[11] = mie_q[1];
      end
      ADDR_MTVEC:    rdata = mtvec_q;
      ADDR_MSCRATCH: rdata = mscratch_q;
      ADDR_MEPC:     rdata = mepc_q;
      ADDR_MCAUSE:   rdata = mcause_q;
      ADDR_MTVAL:    rdata = mtval_q;
      ADDR_MIP: begin
        rdata[7]  = mip_q[0];
        rdata[11] = mip_q[1];
      end
      ADDR_MTAGS:    rdata = mtags_q;
      ADDR_MVENDORID, ADDR_MARCHID: rdata = '0;
      ADDR_MHARTID:  rdata = HART_ID;
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE:   rdata = W'(mcycle_q);
      ADDR_MCYCLEH: begin
        if (W == 32) rdata = W'(mcycle_q[63:32]);
        else         hit   = 1'b0;
      end
`endif
      default:       hit = 1'b0;
    endcase
  end

  always_comb begin
    wval = rdata;
    case (op_q)
      2'd0:    wval = wdata_q;
      2'd1:    wval = rdata | wdata_q;
      2'd2:    wval = rdata & ~wdata_q;
      default: wval = rdata;
    endcase
  end

  assign ro_addr       = (addr_q[11:10] == 2'b11);
  assign do_write      = (state == ACCESS) && (op_q != 2'd3) && hit && !ro_addr;
  assign mtvec_o       = mtvec_q;
  assign mepc_o        = mepc_q;
  assign irq_pending_o = st_mie & |(mip_q & mie_q);

  // Request fields are frozen at acceptance; results and done appear as ACCESS closes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      op_q         <= 2'd3;
      addr_q       <= '0;
      wdata_q      <= '0;
      csr_busy_o   <= 1'b0;
      csr_done_o   <= 1'b0;
      csr_data_o   <= '0;
      csr_exists_o <= 1'b0;
      csr_ro_o     <= 1'b0;
    end else begin
      csr_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (csr_en_i) begin
            op_q       <= csr_op_i;
            addr_q     <= csr_addr_i;
            wdata_q    <= csr_data_i;
            csr_busy_o <= 1'b1;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          csr_data_o   <= rdata;
          csr_exists_o <= hit;
          csr_ro_o     <= ro_addr;
          csr_done_o   <= 1'b1;
          csr_busy_o   <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Trap/mret updates come after the software write so they take precedence on shared fields.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mie_q      <= 2'b00;
      mip_q      <= 2'b00;
      mtvec_q    <= {MTVEC_RESET[W-1:2], 2'b00};
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mtags_q    <= '0;
`ifdef CSR_COUNTERS_EN
      mcycle_q   <= '0;
`endif
    end else begin
      mip_q <= irq_i;
`ifdef CSR_COUNTERS_EN
      mcycle_q <= mcycle_q + 64'd1;
`endif
      if (do_write) begin
        case (addr_q)
          ADDR_MSTATUS: begin
            st_mie  <= wval[3];
            st_mpie <= wval[7];
          end
          ADDR_MIE:      mie_q      <= {wval[11], wval[7]};
          ADDR_MTVEC:    mtvec_q    <= {wval[W-1:2], 2'b00};
          ADDR_MSCRATCH: mscratch_q <= wval;
          ADDR_MEPC:     mepc_q     <= {wval[W-1:2], 2'b00};
          ADDR_MCAUSE:   mcause_q   <= wval;
          ADDR_MTVAL:    mtval_q    <= wval;
          ADDR_MTAGS:    mtags_q    <= wval;
`ifdef CSR_COUNTERS_EN
          ADDR_MCYCLE: begin
            if (W == 64) mcycle_q <= 64'(wval);
            else         mcycle_q <= {mcycle_q[63:32], wval[31:0]};
          end
          ADDR_MCYCLEH:  mcycle_q <= {wval[31:0], mcycle_q[31:0]};
`endif
          default: ;
        endcase
      end
      if (trap_i) begin
        mepc_q   <= {trap_pc_i[W-1:2], 2'b00};
        mcause_q <= trap_cause_i;
        mtval_q  <= trap_val_i;
        st_mpie  <= st_mie;
        st_mie   <= 1'b0;
      end else if (mret_i) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed and randomized checks of csr_unit against a word-level CSR model.
// Build with CSR_COUNTERS_EN defined to also exercise the mcycle/mcycleh counter.
module tb_csr_unit;

  localparam logic [31:0] HART      = 32'd3;
  localparam logic [31:0] MTVEC_RST = 32'h0000_0103;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [11:0] addr = 12'h000;
  logic [31:0] din = '0;
  logic        trap = 1'b0;
  logic [31:0] cause = '0;
  logic [31:0] pc = '0;
  logic [31:0] tval = '0;
  logic        mret = 1'b0;
  logic [1:0]  irq = 2'b00;

  logic [31:0] data_out;
  logic        busy;
  logic        done;
  logic        exists;
  logic        ro_out;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        irq_pend;

  csr_unit #(
    .CSR_DATA_WIDTH(32),
    .CSR_ADDR_WIDTH(12),
    .HART_ID(HART),
    .MTVEC_RESET(MTVEC_RST)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .csr_en_i(en),
    .csr_op_i(op),
    .csr_addr_i(addr),
    .csr_data_i(din),
    .csr_data_o(data_out),
    .csr_busy_o(busy),
    .csr_done_o(done),
    .csr_exists_o(exists),
    .csr_ro_o(ro_out),
    .trap_i(trap),
    .trap_cause_i(cause),
    .trap_pc_i(pc),
    .trap_val_i(tval),
    .mret_i(mret),
    .irq_i(irq),
    .mtvec_o(mtvec),
    .mepc_o(mepc),
    .irq_pending_o(irq_pend)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each CSR is a word with a writable mask; special CSRs are computed on read.
  logic [31:0] mreg [0:4095];
  logic        m_valid = 1'b0;
  logic        m_pending = 1'b0;
  logic [1:0]  p_op = 2'd0;
  logic [11:0] p_addr = 12'h000;
  logic [31:0] p_data = '0;
  logic        e_done = 1'b0;
  logic        e_exists = 1'b0;
  logic        e_ro = 1'b0;
  logic [31:0] e_data = '0;
  logic [1:0]  m_irq = 2'b00;
  logic [63:0] m_cycle = '0;

  function automatic logic m_exists(input logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
      12'h344, 12'h7C0, 12'hF11, 12'hF12, 12'hF14: return 1'b1;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hB80: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_wmask(input logic [11:0] a);
    case (a)
      12'h300: return 32'h0000_0088;
      12'h304: return 32'h0000_0880;
      12'h305, 12'h341: return 32'hFFFF_FFFC;
      12'h340, 12'h342, 12'h343, 12'h7C0: return 32'hFFFF_FFFF;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hB80: return 32'hFFFF_FFFF;
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return mreg[a] | 32'h0000_1800;
      12'h301: return 32'h4000_0100;
      12'h344: return (m_irq[0] ? 32'h80 : 32'h0) | (m_irq[1] ? 32'h800 : 32'h0);
      12'hF14: return HART;
`ifdef CSR_COUNTERS_EN
      12'hB00: return m_cycle[31:0];
      12'hB80: return m_cycle[63:32];
`endif
      default: return m_exists(a) ? mreg[a] : 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic        was_idle;
    logic        do_w;
    logic [31:0] pre_ms;
    logic [31:0] nv;
    logic [63:0] pre_cyc;
    if (rst) begin
      for (int i = 0; i < 4096; i++) mreg[i] = '0;
      mreg[12'h305] = MTVEC_RST & ~32'h3;
      m_pending = 1'b0;
      e_done = 1'b0;
      e_data = '0;
      e_exists = 1'b0;
      e_ro = 1'b0;
      m_irq = 2'b00;
      m_cycle = '0;
      m_valid = 1'b1;
    end else begin
      was_idle = !m_pending;
      pre_ms = mreg[12'h300];
      pre_cyc = m_cycle;
      do_w = 1'b0;
      nv = '0;
      e_done = 1'b0;
      if (m_pending) begin
        e_data = m_read(p_addr);
        e_exists = m_exists(p_addr);
        e_ro = (p_addr[11:10] == 2'b11);
        e_done = 1'b1;
        case (p_op)
          2'd0: nv = p_data;
          2'd1: nv = e_data | p_data;
          2'd2: nv = e_data & ~p_data;
          default: nv = e_data;
        endcase
        do_w = (p_op != 2'd3) && !e_ro && (m_wmask(p_addr) != 32'h0);
        m_pending = 1'b0;
      end
      m_cycle = m_cycle + 64'd1;
      if (do_w) begin
        if (p_addr == 12'hB00) m_cycle = {pre_cyc[63:32], nv};
        else if (p_addr == 12'hB80) m_cycle = {nv, pre_cyc[31:0]};
        else mreg[p_addr] = (mreg[p_addr] & ~m_wmask(p_addr)) | (nv & m_wmask(p_addr));
      end
      if (trap) begin
        mreg[12'h341] = pc & ~32'h3;
        mreg[12'h342] = cause;
        mreg[12'h343] = tval;
        mreg[12'h300] = pre_ms[3] ? 32'h80 : 32'h0;
      end else if (mret) begin
        mreg[12'h300] = 32'h80 | (pre_ms[7] ? 32'h8 : 32'h0);
      end
      m_irq = irq;
      if (was_idle && en) begin
        m_pending = 1'b1;
        p_op = op;
        p_addr = addr;
        p_data = din;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check_output("busy", 64'(busy), 64'(m_pending));
      check_output("done", 64'(done), 64'(e_done));
      check_output("data", 64'(data_out), 64'(e_data));
      check_output("exists", 64'(exists), 64'(e_exists));
      check_output("ro", 64'(ro_out), 64'(e_ro));
      check_output("mtvec", 64'(mtvec), 64'(mreg[12'h305]));
      check_output("mepc", 64'(mepc), 64'(mreg[12'h341]));
      check_output("irq_pending", 64'(irq_pend),
                   64'(mreg[12'h300][3] & ((m_irq[0] & mreg[12'h304][7]) | (m_irq[1] & mreg[12'h304][11]))));
    end
  end

  task automatic apply_stimulus(input logic [1:0] o, input logic [11:0] a, input logic [31:0] d,
                                output logic [31:0] rd, output logic ex, output logic rdo);
    logic got;
    rd = '0;
    ex = 1'b0;
    rdo = 1'b0;
    got = 1'b0;
    @(negedge clk);
    en = 1'b1;
    op = o;
    addr = a;
    din = d;
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        rd = data_out;
        ex = exists;
        rdo = ro_out;
      end
    end
    if (!got) check_output("done_timeout", 64'd0, 64'd1);
  endtask

  logic [11:0] addr_list [17] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                  12'h342, 12'h343, 12'h344, 12'h7C0, 12'hF11, 12'hF12,
                                  12'hF14, 12'hB00, 12'hB80, 12'h7FF, 12'h000};

  initial begin
    logic [31:0] rd;
    logic        ex;
    logic        rdo;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_output("reset_busy", 64'(busy), 64'd0);
    check_output("reset_done", 64'(done), 64'd0);
    check_output("reset_data", 64'(data_out), 64'd0);
    check_output("reset_mtvec", 64'(mtvec), 64'h100);

    apply_stimulus(2'd0, 12'h340, 32'hDEAD_BEEF, rd, ex, rdo);
    apply_stimulus(2'd3, 12'h340, 32'h0, rd, ex, rdo);
    check_output("mscratch_rd", 64'(rd), 64'hDEAD_BEEF);
    check_output("mscratch_exists", 64'(ex), 64'd1);
    check_output("mscratch_ro", 64'(rdo), 64'd0);

    apply_stimulus(2'd0, 12'h300, 32'h8, rd, ex, rdo);
    apply_stimulus(2'd1, 12'h300, 32'h80, rd, ex, rdo);
    check_output("mstatus_set_old", 64'(rd), 64'h1808);
    apply_stimulus(2'd2, 12'h300, 32'h8, rd, ex, rdo);
    check_output("mstatus_clr_old", 64'(rd), 64'h1888);
    apply_stimulus(2'd3, 12'h300, 32'h0, rd, ex, rdo);
    check_output("mstatus_final", 64'(rd), 64'h1880);

    apply_stimulus(2'd0, 12'hF14, 32'h5, rd, ex, rdo);
    check_output("mhartid_rd", 64'(rd), 64'd3);
    check_output("mhartid_ro", 64'(rdo), 64'd1);
    apply_stimulus(2'd3, 12'hF14, 32'h0, rd, ex, rdo);
    check_output("mhartid_again", 64'(rd), 64'd3);
    apply_stimulus(2'd3, 12'h7FF, 32'h0, rd, ex, rdo);
    check_output("hole_exists", 64'(ex), 64'd0);
    check_output("hole_data", 64'(rd), 64'd0);
    apply_stimulus(2'd3, 12'h301, 32'h0, rd, ex, rdo);
    check_output("misa", 64'(rd), 64'h4000_0100);
    apply_stimulus(2'd0, 12'h305, 32'h1237, rd, ex, rdo);
    check_output("mtvec_mask", 64'(mtvec), 64'h1234);

    apply_stimulus(2'd0, 12'h300, 32'h8, rd, ex, rdo);
    trap = 1'b1;
    cause = 32'h8000_000B;
    pc = 32'h104;
    tval = 32'h55;
    @(negedge clk);
    trap = 1'b0;
    check_output("trap_mepc", 64'(mepc), 64'h104);
    apply_stimulus(2'd3, 12'h300, 32'h0, rd, ex, rdo);
    check_output("trap_mstatus", 64'(rd), 64'h1880);
    apply_stimulus(2'd3, 12'h342, 32'h0, rd, ex, rdo);
    check_output("trap_mcause", 64'(rd), 64'h8000_000B);
    mret = 1'b1;
    @(negedge clk);
    mret = 1'b0;
    apply_stimulus(2'd3, 12'h300, 32'h0, rd, ex, rdo);
    check_output("mret_mstatus", 64'(rd), 64'h1888);

    apply_stimulus(2'd0, 12'h304, 32'hFFFF_FFFF, rd, ex, rdo);
    apply_stimulus(2'd3, 12'h304, 32'h0, rd, ex, rdo);
    check_output("mie_mask", 64'(rd), 64'h880);
    check_output("irq_idle", 64'(irq_pend), 64'd0);
    irq = 2'b10;
    @(negedge clk);
    check_output("irq_pending", 64'(irq_pend), 64'd1);
    apply_stimulus(2'd3, 12'h344, 32'h0, rd, ex, rdo);
    check_output("mip_rd", 64'(rd), 64'h800);
    irq = 2'b00;

    @(negedge clk);
    en = 1'b1;
    op = 2'd0;
    addr = 12'h341;
    din = 32'h200;
    @(negedge clk);
    en = 1'b0;
    trap = 1'b1;
    pc = 32'h300;
    cause = 32'h2;
    tval = 32'h0;
    @(negedge clk);
    trap = 1'b0;
    check_output("trapwin_done", 64'(done), 64'd1);
    check_output("trapwin_old", 64'(data_out), 64'h104);
    check_output("trapwin_mepc", 64'(mepc), 64'h300);

    @(negedge clk);
    en = 1'b1;
    op = 2'd0;
    addr = 12'h340;
    din = 32'h1234;
    @(negedge clk);
    en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("abort_done", 64'(done), 64'd0);
    check_output("abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check_output("abort_no_pulse", 64'(done), 64'd0);

`ifdef CSR_COUNTERS_EN
    apply_stimulus(2'd0, 12'hB00, 32'hFFFF_FFFF, rd, ex, rdo);
    apply_stimulus(2'd3, 12'hB80, 32'h0, rd, ex, rdo);
    check_output("mcycleh_wrap", 64'(rd), 64'd1);
`endif

    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      en = ($urandom_range(0, 2) == 0);
      op = 2'($urandom_range(0, 3));
      addr = addr_list[$urandom_range(0, 16)];
      din = ($urandom_range(0, 3) == 0) ? 32'h0000_0888 : $urandom;
      trap = ($urandom_range(0, 15) == 0);
      mret = ($urandom_range(0, 15) == 1);
      cause = $urandom;
      pc = $urandom;
      tval = $urandom;
      if (c % 7 == 0) irq = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    trap = 1'b0;
    mret = 1'b0;
    irq = 2'b00;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/csr_unit.md
CSR_UNIT -- requirements
Module: csr_unit
Interface
REQ-001 CSR_DATA_WIDTH, 32, register width; legal values 32 or 64.
REQ-002 CSR_ADDR_WIDTH, 12, CSR address width.
REQ-003 HART_ID, 0, constant returned by mhartid.
REQ-004 MTVEC_RESET, 0, mtvec reset value; bits [1:0] ignored.
REQ-005 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 csr_en_i  in  1  access request; sampled only while csr_busy_o=0.
REQ-008 csr_op_i  in  2  0=write, 1=set bits, 2=clear bits, 3=read only.
REQ-009 csr_addr_i  in  CSR_ADDR_WIDTH  CSR address.
REQ-010 csr_data_i  in  CSR_DATA_WIDTH  write/set/clear operand.
REQ-011 csr_data_o  out  CSR_DATA_WIDTH  old CSR value of last access.
REQ-012 csr_busy_o  out  1  access in progress.
REQ-013 csr_done_o  out  1  one-cycle pulse: csr_data_o/exists/ro valid.
REQ-014 csr_exists_o  out  1  last address implemented.
REQ-015 csr_ro_o  out  1  last address read-only (addr[11:10]==2'b11).
REQ-016 trap_i  in  1  trap entry pulse; trap_cause_i/trap_pc_i/trap_val_i (each CSR_DATA_WIDTH) qualify it.
REQ-017 mret_i  in  1  trap-return pulse.
REQ-018 irq_i  in  2  level interrupts: [0] timer, [1] external.
REQ-019 mtvec_o, mepc_o  out  CSR_DATA_WIDTH  current mtvec/mepc.
REQ-020 irq_pending_o  out  1  mstatus.MIE & |(mip & mie).
Function
REQ-021 Map: mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mtags 0x7C0, mvendorid 0xF11, marchid 0xF12, mhartid 0xF14; others: exists=0, read 0.
REQ-022 FSM IDLE->ACCESS->IDLE; en accepted in IDLE moves to ACCESS at next edge, busy=1 in ACCESS.
REQ-023 ACCESS cycle: csr_data_o, exists, ro registered; done=1; write committed at end of ACCESS; return to IDLE; latency en->done 1 cycle, back-to-back every 2 cycles.
REQ-024 New value = op0: d; op1: old|d; op2: old&~d; op3: no write.
REQ-025 Write suppressed when address nonexistent or read-only; read still returned.
REQ-026 Write masks: mstatus only MIE[3], MPIE[7]; MPP[12:11] reads 2'b11; mie only bits 7,11; mtvec/mepc bits [1:0] read 0; mip read-only, bit7=irq_i[0], bit11=irq_i[1].
REQ-027 misa reads MXL (1 for 32, 2 for 64) in top two bits plus I bit[8]; mvendorid/marchid read 0.
REQ-028 trap_i: mepc<=trap_pc_i, mcause<=trap_cause_i, mtval<=trap_val_i, MPIE<=MIE, MIE<=0 at the same edge.
REQ-029 mret_i: MIE<=MPIE, MPIE<=1; trap_i and mret_i together: trap_i wins.
REQ-030 trap_i/mret_i coinciding with an ACCESS write to the same CSR: hardware update wins, software write to those fields dropped.
REQ-031 en while busy ignored; op/addr/data latched at acceptance only.
Reset
REQ-032 rst_i: state IDLE, busy=0, done=0, csr_data_o=0, exists=0, ro=0, mstatus MIE=MPIE=0, mie=0, mtvec=MTVEC_RESET&~3, other writable CSRs 0.
REQ-033 rst_i during ACCESS aborts it: no write, no done pulse.
Configuration
REQ-034 CSR_COUNTERS_EN defined: 64-bit mcycle at 0xB00 (+mcycleh 0xB80 when width 32) increments every non-reset cycle, writable; software write replaces increment that cycle.
REQ-035 CSR_COUNTERS_EN undefined: 0xB00/0xB80 nonexistent, read 0, no counter logic.
Verification
REQ-036 Reset, en op0 0x340 d=0xDEADBEEF then op3 0x340 -> second done returns 0xDEADBEEF, exists=1, ro=0.
REQ-037 mstatus=0x8, op1 d=0x80 -> returns 0x1808; op2 d=0x8 -> returns 0x1888; final read 0x1880.
REQ-038 op0 0xF14 d=0x5 with HART_ID=3 -> returns 3, ro=1, later read still 3; addr 0x7FF -> exists=0, data 0.
REQ-039 MIE=1, trap_i cause=0x8000000B pc=0x104 -> mepc 0x104, MIE=0, MPIE=1; mret_i -> MIE=1.
REQ-040 mie=0x880, MIE=1, irq_i=2'b10 -> irq_pending_o=1 next cycle; mip reads 0x800.
REQ-041 CSR_COUNTERS_EN: write mcycle=0xFFFFFFFF (width 32) -> mcycleh increments to 1 on wrap.
